// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared definitions for the core-side memory responders:
//                FSM state encoding, wait-counter sizing and the word
//                address check (alignment + range).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Largest supported number of wait states; sizes the wait counter.
    localparam int LAT_MAX = 15;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A word access is illegal when the byte address is not word aligned or
    // the word index lies beyond the end of the array.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder_if
//  Description : Request/response channel pair between the core (master) and
//                a memory responder (slave). Both channels are valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/mem_word_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_word_array
//  Description : Word-addressed storage with synchronous write and registered
//                read. Contents are never cleared by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_word_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32
) (
    input  wire logic                     clk,
    input  wire logic                     wr_en,
    input  wire logic                     rd_en,
    input  wire logic [$clog2(DEPTH)-1:0] idx,
    input  wire logic [DATA_W-1:0]        wdata,
    output logic      [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write and read share one index; read data is held until the next read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wdata;
        end
        if (rd_en) begin
            rdata <= mem[idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Data-memory responder for the MIPS core. Accepts one word
//                load/store at a time, waits LATENCY cycles, performs the
//                access and presents data/status until the response is taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int DATA_W  = 32
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    data_mem_responder_if.slave bus
);

    localparam int                IDX_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              rdata_sel;

    logic              accept;
    logic              do_access;
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic              acc_err;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] arr_rdata;

    // Select the live request (zero-latency access) or the latched one, and
    // decide whether the access happens on this edge.
    always_comb begin
        accept    = bus.req_valid && req_ready_q && (state == IDLE);
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        if (state == IDLE) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
        end
        do_access = (accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == '0));
        acc_err   = addr_err(acc_addr, DEPTH);
        // A reset edge must never commit a store still in flight.
        wr_en     = do_access && acc_we && !acc_err && reset_n;
        rd_en     = do_access && !acc_we && !acc_err;
    end

    mem_word_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .idx   (acc_addr[IDX_W+1:2]),
        .wdata (acc_wdata[DATA_W-1:0]),
        .rdata (arr_rdata)
    );

    // Request/wait/response sequencing with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_sel   <= 1'b0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        lat_we      <= bus.req_we;
                        lat_addr    <= bus.req_addr;
                        lat_wdata   <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 0) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= acc_err;
                            rdata_sel   <= !acc_we && !acc_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= acc_err;
                        rdata_sel   <= !acc_we && !acc_err;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rdata_sel   <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Load data comes straight from the array's read register; stores and
    // errors present zero.
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rdata_sel ? arr_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Directed bench for data_mem_responder. Three instances with
//                LATENCY 0, 2 and 4 (slots 0, 1, 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic [2:0]  reset_n_d;
    logic [2:0]  req_valid_d;
    logic [2:0]  req_we_d;
    logic [2:0]  rsp_ready_d;
    logic [31:0] addr_d  [3];
    logic [31:0] wdata_d [3];

    logic [2:0]  req_ready_o;
    logic [2:0]  rsp_valid_o;
    logic [2:0]  rsp_err_o;
    logic [31:0] rdata_o [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus2 ();
    data_mem_responder_if bus4 ();

    assign bus0.req_valid = req_valid_d[0];
    assign bus0.req_we    = req_we_d[0];
    assign bus0.req_addr  = addr_d[0];
    assign bus0.req_wdata = wdata_d[0];
    assign bus0.rsp_ready = rsp_ready_d[0];
    assign bus2.req_valid = req_valid_d[1];
    assign bus2.req_we    = req_we_d[1];
    assign bus2.req_addr  = addr_d[1];
    assign bus2.req_wdata = wdata_d[1];
    assign bus2.rsp_ready = rsp_ready_d[1];
    assign bus4.req_valid = req_valid_d[2];
    assign bus4.req_we    = req_we_d[2];
    assign bus4.req_addr  = addr_d[2];
    assign bus4.req_wdata = wdata_d[2];
    assign bus4.rsp_ready = rsp_ready_d[2];

    assign req_ready_o = {bus4.req_ready, bus2.req_ready, bus0.req_ready};
    assign rsp_valid_o = {bus4.rsp_valid, bus2.rsp_valid, bus0.rsp_valid};
    assign rsp_err_o   = {bus4.rsp_err,   bus2.rsp_err,   bus0.rsp_err};
    assign rdata_o[0]  = bus0.rsp_rdata;
    assign rdata_o[1]  = bus2.rsp_rdata;
    assign rdata_o[2]  = bus4.rsp_rdata;

    data_mem_responder #(.DEPTH(256), .LATENCY(0), .DATA_W(32)) u_dut0 (
        .clk(clk), .reset_n(reset_n_d[0]), .bus(bus0.slave));
    data_mem_responder #(.DEPTH(256), .LATENCY(2), .DATA_W(32)) u_dut2 (
        .clk(clk), .reset_n(reset_n_d[1]), .bus(bus2.slave));
    data_mem_responder #(.DEPTH(256), .LATENCY(4), .DATA_W(32)) u_dut4 (
        .clk(clk), .reset_n(reset_n_d[2]), .bus(bus4.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transaction on slot s. lat counts clock edges from the
    // accepting edge (inclusive) to the first cycle with rsp_valid high.
    task automatic xact(input int s, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
        int n;
        @(negedge clk);
        req_we_d[s]    = we;
        addr_d[s]      = addr;
        wdata_d[s]     = wdata;
        req_valid_d[s] = 1'b1;
        n = 0;
        while (!req_ready_o[s] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_timeout", 32'(n < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid_d[s] = 1'b0;
        lat = 1;
        while (!rsp_valid_o[s] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_valid_timeout", 32'(lat < 40), 32'd1);
        rdata = rdata_o[s];
        err   = rsp_err_o[s];
        rsp_ready_d[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready_d[s] = 1'b0;
        check("rsp_valid_after_hs", 32'(rsp_valid_o[s]), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;

        reset_n_d   = 3'b000;
        req_valid_d = 3'b000;
        req_we_d    = 3'b000;
        rsp_ready_d = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr_d[i]  = 32'h0;
            wdata_d[i] = 32'h0;
        end

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_req_ready", 32'(req_ready_o[1]), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid_o[1]), 32'd0);
        end
        check("rst_rsp_rdata", rdata_o[1], 32'h0);
        check("rst_rsp_err", 32'(rsp_err_o[1]), 32'd0);
        reset_n_d = 3'b111;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready_o[1]), 32'd1);

        // Store then load, LATENCY=2.
        xact(1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, er, lat);
        check("st_rdata", rd, 32'h0);
        check("st_err", 32'(er), 32'd0);
        check("st_lat", 32'(lat), 32'd3);
        xact(1, 1'b0, 32'h0000_0010, 32'h0, rd, er, lat);
        check("ld_rdata", rd, 32'hDEAD_BEEF);
        check("ld_err", 32'(er), 32'd0);
        check("ld_lat", 32'(lat), 32'd3);

        // Misaligned store must not write.
        xact(1, 1'b1, 32'h0000_0012, 32'h1111_2222, rd, er, lat);
        check("mis_err", 32'(er), 32'd1);
        check("mis_rdata", rd, 32'h0);
        xact(1, 1'b0, 32'h0000_0010, 32'h0, rd, er, lat);
        check("mis_ld_rdata", rd, 32'hDEAD_BEEF);

        // Range boundary for DEPTH=256.
        xact(1, 1'b0, 32'h0000_0400, 32'h0, rd, er, lat);
        check("oor_err", 32'(er), 32'd1);
        check("oor_rdata", rd, 32'h0);
        xact(1, 1'b0, 32'h0000_03FC, 32'h0, rd, er, lat);
        check("last_word_err", 32'(er), 32'd0);

        // Backpressure with req_valid held high throughout.
        @(negedge clk);
        req_we_d[1]    = 1'b0;
        addr_d[1]      = 32'h0000_0010;
        req_valid_d[1] = 1'b1;
        @(posedge clk);
        n = 0;
        @(negedge clk);
        while (!rsp_valid_o[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_timeout", 32'(n < 20), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid_o[1]), 32'd1);
            check("bp_rdata", rdata_o[1], 32'hDEAD_BEEF);
            check("bp_err", 32'(rsp_err_o[1]), 32'd0);
            check("bp_req_ready", 32'(req_ready_o[1]), 32'd0);
        end
        rsp_ready_d[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready_d[1] = 1'b0;
        check("bp_rel_rsp_valid", 32'(rsp_valid_o[1]), 32'd0);
        check("bp_rel_req_ready", 32'(req_ready_o[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid_d[1] = 1'b0;
        check("bp_second_accept", 32'(req_ready_o[1]), 32'd0);
        n = 0;
        while (!rsp_valid_o[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp2_rsp_timeout", 32'(n < 20), 32'd1);
        check("bp2_rdata", rdata_o[1], 32'hDEAD_BEEF);
        rsp_ready_d[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready_d[1] = 1'b0;

        // LATENCY=0 store and load.
        xact(0, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, rd, er, lat);
        check("l0_st_lat", 32'(lat), 32'd1);
        check("l0_st_rdata", rd, 32'h0);
        xact(0, 1'b0, 32'h0000_0004, 32'h0, rd, er, lat);
        check("l0_ld_lat", 32'(lat), 32'd1);
        check("l0_ld_rdata", rd, 32'hCAFE_F00D);

        // LATENCY=4: reset during WAIT aborts a store.
        xact(2, 1'b1, 32'h0000_0020, 32'hAAAA_5555, rd, er, lat);
        check("l4_st_lat", 32'(lat), 32'd5);
        @(negedge clk);
        req_we_d[2]    = 1'b1;
        addr_d[2]      = 32'h0000_0020;
        wdata_d[2]     = 32'h1234_5678;
        req_valid_d[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_d[2] = 1'b0;
        @(negedge clk);
        reset_n_d[2] = 1'b0;
        @(negedge clk);
        check("l4_rst_rsp_valid", 32'(rsp_valid_o[2]), 32'd0);
        check("l4_rst_req_ready", 32'(req_ready_o[2]), 32'd0);
        reset_n_d[2] = 1'b1;
        xact(2, 1'b0, 32'h0000_0020, 32'h0, rd, er, lat);
        check("l4_abort_rdata", rd, 32'hAAAA_5555);
        check("l4_ld_lat", 32'(lat), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the single-cycle MIPS core's load/store traffic: it accepts word read/write requests on a valid/ready request channel and returns data and status on a valid/ready response channel. It models a data memory with a configurable number of wait states. This lets the core be exercised against non-zero-latency memory ahead of the multi-cycle/pipelined datapath work. It owns the word array and checks addresses for alignment and range.

Parameters:
DEPTH, 256, number of 32-bit words in the array; power of two, minimum 4
LATENCY, 2, wait cycles between request acceptance and response; legal range 0..15
DATA_W, 32, data width; fixed at 32, exposed for documentation only

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store word, 0 = load word
req_addr  input  32  byte address (ALU_Out from core)
req_wdata  input  32  store data (WriteData from core)
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts response
rsp_rdata  output  32  load data; 0 for stores and errors
rsp_err  output  1  1 = misaligned or out-of-range access

Behaviour:
- One clock (clk). Reset is synchronous and active-low (reset_n sampled on the rising clk edge).
- Reset: state IDLE, wait counter 0, req_ready=0 during the reset cycle and 1 from the first cycle after, rsp_valid=0, rsp_rdata=0, rsp_err=0. Array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1, the request is accepted at the clock edge and req_we, req_addr and req_wdata are latched.
  - Next state is WAIT with counter=LATENCY-1 if LATENCY>0; otherwise RESP.
- WAIT:
  - req_ready=0. The counter decrements each cycle.
  - At counter==0 the access is performed and the state moves to RESP.
  - Request inputs are ignored.
- Access, performed on the edge that enters RESP:
  - err = (addr[1:0]!=0) OR (addr[31:2] >= DEPTH).
  - Word index = addr[log2(DEPTH)+1:2].
  - Load, no error: rsp_rdata = array[index].
  - Store, no error: array[index] = wdata, rsp_rdata = 0.
  - Any error: no array write, rsp_rdata = 0, rsp_err = 1.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On the handshake edge: return to IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=0 in RESP, so no pipelining of requests.
- Latency: acceptance at edge N gives rsp_valid high from cycle N+1+LATENCY. With rsp_ready held at 1, req_ready returns at N+2+LATENCY.
- Read-after-write: a load accepted after a store's response handshake returns the stored data. No forwarding is needed because only one request is outstanding at a time.
- Reset mid-operation:
  - Reset in WAIT aborts the request; a pending store is not committed.
  - Reset in RESP drops the response; a store already committed stays committed.
- rsp_ready=1 outside RESP is ignored.
- req_valid held high through WAIT/RESP is not a new request; it is accepted only on return to IDLE.

Decomposition:
- Shared package mem_pkg holds:
  - state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - LAT_MAX=15
  - the address-check function (alignment + range) for reuse by the future instruction-memory responder
- One sub-module, mem_word_array: synchronous-write, registered-read, word-addressed array with DEPTH parameter. The FSM, counter and error logic stay in data_mem_responder.

Test Plan:
- Reset, LATENCY=2: hold reset_n=0 for 3 cycles -> req_ready=0 and rsp_valid=0 during reset; req_ready=1 on the first cycle after reset_n=1.
- Store then load: store addr 0x0000_0010, data 0xDEADBEEF; after its response, load 0x10 -> store response rsp_rdata=0, rsp_err=0; load response rsp_rdata=0xDEADBEEF, rsp_valid exactly 3 cycles after acceptance.
- Misaligned store to 0x0000_0012, then load 0x10 -> store response rsp_err=1, rsp_rdata=0; load still returns 0xDEADBEEF (no write occurred).
- Out of range, DEPTH=256: load 0x0000_0400 -> rsp_err=1, rsp_rdata=0; load 0x0000_03FC -> rsp_err=0.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP while req_valid=1 -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0, no second acceptance; release -> IDLE next cycle and the pending request is accepted.
- LATENCY=0 and reset-in-WAIT: with LATENCY=0, rsp_valid appears one cycle after acceptance. With LATENCY=4, assert reset_n=0 two cycles after a store of 0x12345678 to 0x20, then load 0x20 -> old contents returned (store aborted).
